// File: rtl/mmio_arb_pkg.sv
// Shared types and sizes for the two-master MMIO bus arbiter.
package mmio_arb_pkg;
  localparam int N_MASTERS   = 2;
  localparam int MMIO_ADDR_W = 21;
  localparam int MMIO_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
  typedef logic master_id_t;
endpackage

// File: rtl/mmio_bus_arbiter_if.sv
// Master-side handshakes and the downstream FPro MMIO bus, bundled for the arbiter.
interface mmio_bus_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
);
  logic              m0_req, m0_wr, m0_rd, m0_ack;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wr_data, m0_rd_data;
  logic              m1_req, m1_wr, m1_rd, m1_ack;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wr_data, m1_rd_data;
  logic              mmio_cs, mmio_wr, mmio_rd;
  logic [ADDR_W-1:0] mmio_addr;
  logic [DATA_W-1:0] mmio_wr_data, mmio_rd_data;
  logic              busy, grant_id;

  modport slave (
    input  m0_req, m0_wr, m0_rd, m0_addr, m0_wr_data,
    input  m1_req, m1_wr, m1_rd, m1_addr, m1_wr_data,
    input  mmio_rd_data,
    output m0_ack, m0_rd_data, m1_ack, m1_rd_data,
    output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    output busy, grant_id
  );

  modport master (
    output m0_req, m0_wr, m0_rd, m0_addr, m0_wr_data,
    output m1_req, m1_wr, m1_rd, m1_addr, m1_wr_data,
    output mmio_rd_data,
    input  m0_ack, m0_rd_data, m1_ack, m1_rd_data,
    input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    input  busy, grant_id
  );
endinterface

// File: rtl/mmio_rr_arb2.sv
// Combinational two-way grant selector. MMIO_ARB_FIXED_PRIO_EN makes master 0
// win every contention; otherwise the master other than last_grant wins.
module mmio_rr_arb2
  import mmio_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t last_grant,
  input  logic       enable,
  output logic       gnt_valid,
  output master_id_t gnt_id
);
`ifdef MMIO_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    gnt_valid = enable & (|req);
    gnt_id    = 1'b0;
    if (req == 2'b11) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
      gnt_id = 1'b0;
`else
      gnt_id = ~last_grant;
`endif
    end else begin
      gnt_id = req[1];
    end
  end
endmodule

// File: rtl/mmio_bus_arbiter.sv
// Shares one FPro MMIO bus between two masters, one transaction at a time.
// Build option: MMIO_ARB_FIXED_PRIO_EN selects fixed priority for master 0.
module mmio_bus_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int ADDR_W = MMIO_ADDR_W,
  parameter int DATA_W = MMIO_DATA_W
) (
  input logic          clk,
  input logic          reset,
  mmio_bus_arbiter_if.slave bus
);
  arb_state_t             state, state_d;
  master_id_t             last_grant, gnt_id;
  logic                   gnt_valid;
  logic [N_MASTERS-1:0]   req_vec;
  logic                   sel_wr, sel_rd;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wr_data;

  assign req_vec = {bus.m1_req, bus.m0_req};

  mmio_rr_arb2 u_arb (
    .req        (req_vec),
    .last_grant (last_grant),
    .enable     (state == IDLE),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    sel_wr      = bus.m0_wr;
    sel_rd      = bus.m0_rd;
    sel_addr    = bus.m0_addr;
    sel_wr_data = bus.m0_wr_data;
    if (gnt_id) begin
      sel_wr      = bus.m1_wr;
      sel_rd      = bus.m1_rd;
      sel_addr    = bus.m1_addr;
      sel_wr_data = bus.m1_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    bus.busy = (state != IDLE);
    unique case (state)
      IDLE:    if (gnt_valid) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture at grant; completion, read capture and ack at the end of ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mmio_cs      <= 1'b0;
      bus.mmio_wr      <= 1'b0;
      bus.mmio_rd      <= 1'b0;
      bus.mmio_addr    <= '0;
      bus.mmio_wr_data <= '0;
      bus.m0_ack       <= 1'b0;
      bus.m1_ack       <= 1'b0;
      bus.m0_rd_data   <= '0;
      bus.m1_rd_data   <= '0;
      bus.grant_id     <= 1'b0;
      last_grant       <= 1'b1;
    end else begin
      bus.m0_ack <= 1'b0;
      bus.m1_ack <= 1'b0;
      case (state)
        IDLE: if (gnt_valid) begin
          bus.mmio_cs      <= 1'b1;
          bus.mmio_wr      <= sel_wr;
          bus.mmio_rd      <= sel_rd & ~sel_wr;
          bus.mmio_addr    <= sel_addr;
          bus.mmio_wr_data <= sel_wr_data;
          bus.grant_id     <= gnt_id;
        end
        ISSUE: begin
          bus.mmio_cs <= 1'b0;
          bus.mmio_wr <= 1'b0;
          bus.mmio_rd <= 1'b0;
          last_grant  <= bus.grant_id;
          if (bus.grant_id) begin
            bus.m1_ack <= 1'b1;
            if (bus.mmio_rd) bus.m1_rd_data <= bus.mmio_rd_data;
          end else begin
            bus.m0_ack <= 1'b1;
            if (bus.mmio_rd) bus.m0_rd_data <= bus.mmio_rd_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
